pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : hazard/stall controller for a 5-stage in-order pipeline.
// Optional macro PIPE_CTRL_PERF_EN builds a saturating stall-cycle counter.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             mem_req_valid,
  input  logic             mem_ready,
  input  logic             trap,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TO_W = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              lu_bubble_q, lu_bubble_d;

  logic mem_stall;
  logic load_use;
  logic md_stall;

  assign mem_stall = mem_req_valid & ~mem_ready;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));
  assign md_stall  = ((state_q == RUN) && ex_md_start && !md_done) ||
                     ((state_q == MD_WAIT) && !md_done);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    mem_timeout  = 1'b0;
    state_d      = state_q;
    to_cnt_d     = '0;
    lu_bubble_d  = 1'b0;

    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = RUN;
    end else if (trap) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
    end else if ((state_q == MEM_WAIT) && mem_stall && (to_cnt_q == TO_W'(TIMEOUT))) begin
      // Give up on the access: drain the whole pipe and restart fetch.
      mem_timeout  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = RUN;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      // A memory stall during a mul/div wait must not lose the MD_WAIT state.
      if (state_q != MD_WAIT) begin
        state_d  = MEM_WAIT;
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else if (state_q == MEM_WAIT) begin
      state_d = RUN;
    end else if (md_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      state_d      = MD_WAIT;
    end else if (state_q == MD_WAIT) begin
      state_d = RUN;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use && !lu_bubble_q) begin
      // After one bubble the load has left EX, so a repeat hit is stale input.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      lu_bubble_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      lu_bubble_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      lu_bubble_q <= lu_bubble_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed scoreboard bench for pipe_ctrl (TIMEOUT=4).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int TO = 4;
  localparam int CW = 16;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //  ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_timeout}
  localparam logic [9:0] C_DEF  = 10'b11_01_01_01_0_0 ;
  localparam logic [9:0] C_RST  = 10'b11_1_11_11_11_0;
  localparam logic [9:0] C_TRAP = 10'b11_1_11_11_10_0;
  localparam logic [9:0] C_MEM  = 10'b00_0_00_00_11_0;
  localparam logic [9:0] C_TO   = 10'b11_1_11_11_11_1;
  localparam logic [9:0] C_MD   = 10'b00_0_00_11_10_0;
  localparam logic [9:0] C_BR   = 10'b11_1_11_10_10_0;
  localparam logic [9:0] C_LU   = 10'b00_0_11_10_10_0;

  typedef struct {
    logic [9:0] ctl;
    string      tag;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
  logic          ex_md_start, md_done, mem_req_valid, mem_ready, trap;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_timeout;
  logic [CW-1:0] stall_cycles;

  exp_t          sb[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [CW-1:0] model_stall = '0;

  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .md_done(md_done),
    .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
    .trap(trap),
    .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0; ex_branch_taken = 0;
    ex_md_start = 0; md_done = 0; mem_req_valid = 0; mem_ready = 0; trap = 0;
  endtask

  // Push the expectation for the inputs just driven, then check mid-cycle.
  task automatic step(input logic [9:0] e, input string tag);
    exp_t          x;
    logic [9:0]    obs;
    logic [CW-1:0] exp_sc;
    sb.push_back('{e, tag});
    @(negedge clk);
    x   = sb.pop_front();
    obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_timeout};
    n_cmp++;
    assert (obs === x.ctl) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", x.tag, obs, x.ctl);
    end
`ifdef PIPE_CTRL_PERF_EN
    exp_sc = model_stall;
`else
    exp_sc = '0;
`endif
    n_cmp++;
    assert (stall_cycles === exp_sc) else begin
      n_fail++;
      $error("FAIL %s/stall_cycles: observed %0d expected %0d", x.tag, stall_cycles, exp_sc);
    end
    if (rst) model_stall = '0;
    else if (!x.ctl[9] && model_stall != {CW{1'b1}}) model_stall = model_stall + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    step(C_RST, "reset");
    rst = 0;
    step(C_DEF, "idle");

    // load-use on rs1: exactly one bubble
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
    step(C_LU, "lu_rs1");
    step(C_DEF, "lu_one_bubble");
    clr();
    ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
    step(C_DEF, "lu_x0");
    clr();
    ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1; id_rs1 = 5'd7;
    step(C_LU, "lu_rs2");
    clr();
    step(C_DEF, "lu_clear");

    // mul/div: four wait cycles then done
    ex_md_start = 1;
    for (int i = 0; i < 4; i++) step(C_MD, "md_wait");
    md_done = 1;
    step(C_DEF, "md_done");
    clr();
    ex_md_start = 1; md_done = 1;
    step(C_DEF, "md_same_cycle");
    clr();

    // memory: three frozen cycles then accept
    mem_req_valid = 1;
    for (int i = 0; i < 3; i++) step(C_MEM, "mem_wait");
    mem_ready = 1;
    step(C_DEF, "mem_ready");
    clr();
    step(C_DEF, "mem_idle");

    // memory timeout in the fifth cycle
    mem_req_valid = 1;
    for (int i = 0; i < 4; i++) step(C_MEM, "to_wait");
    step(C_TO, "timeout");
    step(C_MEM, "after_timeout_restall");
    clr();
    step(C_DEF, "to_release");

    // priorities
    trap = 1; mem_req_valid = 1; ex_branch_taken = 1;
    step(C_TRAP, "prio_trap");
    clr();
    step(C_DEF, "prio_clear");
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1;
    step(C_BR, "prio_branch");
    clr();

    // memory stall nested in mul/div wait
    ex_md_start = 1;
    step(C_MD, "nest_md");
    mem_req_valid = 1;
    step(C_MEM, "nest_mem");
    mem_req_valid = 0;
    step(C_MD, "nest_md_kept");
    md_done = 1;
    step(C_DEF, "nest_done");
    clr();

    // load-use masked by memory stall, seen again after release
    mem_req_valid = 1; ex_mem_read = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_used = 1;
    step(C_MEM, "mask_mem");
    mem_ready = 1;
    step(C_DEF, "mask_release");
    mem_req_valid = 0; mem_ready = 0;
    step(C_LU, "mask_lu");
    clr();
    step(C_DEF, "mask_clear");

    // trap aborts mul/div wait
    ex_md_start = 1;
    step(C_MD, "trap_md");
    trap = 1;
    step(C_TRAP, "trap_in_md");
    clr();
    step(C_DEF, "trap_run");

    // reset mid memory stall; timeout counter restarts from zero
    mem_req_valid = 1;
    step(C_MEM, "rst_mem1");
    step(C_MEM, "rst_mem2");
    rst = 1;
    step(C_RST, "rst_in_mem");
    rst = 0;
    for (int i = 0; i < 4; i++) step(C_MEM, "rst_restart");
    step(C_TO, "rst_timeout");
    clr();
    step(C_DEF, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
